// File: rtl/opb_regbank_pkg.sv
// Shared constants and byte-lane helper for the OPB register bank.
// Combinational only; no latency.
// No flow control.
package opb_regbank_pkg;

    localparam logic [5:0]  COMMIT_WORD = 6'd63;
    localparam logic [31:0] WINDOW_MASK = 32'hFFFFFF00;

    // OPB numbers bits MSB-first: DBus[31-k] is register bit k, BE[j] covers register byte 3-j.
    function automatic logic [31:0] be_merge(
        input logic [31:0] old,
        input logic [0:31] dbus,
        input logic [0:3]  be
    );
        logic [31:0] res;
        for (int k = 0; k < 32; k++) begin
            res[k] = be[3 - k / 8] ? dbus[31 - k] : old[k];
        end
        return res;
    endfunction

endpackage

// File: rtl/opb_slave_ack.sv
// OPB slave window decode and single-cycle transfer acknowledge.
// Ack one cycle after select is sampled; errAck shares the ack cycle.
// No backpressure; ack_q blocks a second ack for the same held select.
module opb_slave_ack
    import opb_regbank_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR = 32'h01112100
) (
    input  logic        core_clk,
    input  logic        arst_n,
    input  logic [0:31] abus,
    input  logic        select,
    input  logic        err_req,
    output logic        xfer_start,
    output logic [5:0]  word,
    output logic        xfer_ack,
    output logic        err_ack
);

    logic [31:0] addr;
    logic        hit;
    logic        unused_addr;

    assign addr        = abus;
    assign unused_addr = ^addr[1:0];
    assign hit         = select && ((addr & WINDOW_MASK) == C_BASEADDR);
    assign xfer_start  = hit && !xfer_ack;
    assign word        = addr[7:2];

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            xfer_ack <= 1'b0;
            err_ack  <= 1'b0;
        end else begin
            xfer_ack <= xfer_start;
            err_ack  <= xfer_start && err_req;
        end
    end

endmodule

// File: rtl/opb_register_bank_ppc2simulink.sv
// Software-writable OPB register bank driving static controls into user logic.
// Writes land and strobe in the xferAck cycle, one cycle after select.
// No backpressure; optional shadow set is published atomically on commit.
module opb_register_bank_ppc2simulink
    import opb_regbank_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR     = 32'h01112100,
    parameter logic [31:0] C_HIGHADDR     = 32'h011121FF,
    parameter int          C_NUM_REGS     = 8,
    parameter int          C_DWIDTH       = 32,
    parameter logic [31:0] C_RESET_VAL    = 32'h0,
    parameter int          C_SHADOWED     = 0,
    parameter int          C_ERR_UNMAPPED = 0
) (
    input  logic                             OPB_Clk,
    input  logic                             OPB_Rst_n,
    input  logic [0:31]                      OPB_ABus,
    input  logic [0:3]                       OPB_BE,
    input  logic [0:31]                      OPB_DBus,
    input  logic                             OPB_RNW,
    input  logic                             OPB_select,
    input  logic                             OPB_seqAddr,
    output logic [0:31]                      Sl_DBus,
    output logic                             Sl_xferAck,
    output logic                             Sl_errAck,
    output logic                             Sl_retry,
    output logic                             Sl_toutSup,
    output logic [C_NUM_REGS*C_DWIDTH-1:0]   user_data_out,
    output logic [C_NUM_REGS-1:0]            user_update,
    output logic                             user_commit
);

    localparam logic [C_DWIDTH-1:0] RST_VAL      = C_RESET_VAL[C_DWIDTH-1:0];
    localparam logic [5:0]          NUM_W        = 6'(C_NUM_REGS);
    localparam bit                  SHADOWED     = (C_SHADOWED != 0);
    localparam bit                  ERR_UNMAPPED = (C_ERR_UNMAPPED != 0);

    if (C_HIGHADDR - C_BASEADDR + 32'd1 != 32'd256) begin : g_bad_window
        $error("register bank window must span exactly 256 bytes");
    end

    logic [C_DWIDTH-1:0]   regs   [C_NUM_REGS];
    logic [C_DWIDTH-1:0]   shadow [C_NUM_REGS];
    logic [C_NUM_REGS-1:0] dirty;
    logic [31:0]           rd_q;
    logic [31:0]           rd_nxt;
    logic [31:0]           cur_ext;
    logic [31:0]           merged;
    logic                  commit_q;
    logic                  xfer_start;
    logic                  xfer_ack;
    logic                  err_ack;
    logic                  err_req;
    logic                  mapped;
    logic                  commit_wr;
    logic [5:0]            word;
    logic                  unused_seq;

    assign unused_seq = OPB_seqAddr;

    opb_slave_ack #(
        .C_BASEADDR (C_BASEADDR)
    ) u_ack (
        .core_clk   (OPB_Clk),
        .arst_n     (OPB_Rst_n),
        .abus       (OPB_ABus),
        .select     (OPB_select),
        .err_req    (err_req),
        .xfer_start (xfer_start),
        .word       (word),
        .xfer_ack   (xfer_ack),
        .err_ack    (err_ack)
    );

    // Software always sees the value it last wrote: shadow when shadowed, else the live register.
    always_comb begin
        mapped  = word < NUM_W;
        cur_ext = '0;
        rd_nxt  = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            if (word == 6'(i)) begin
                cur_ext[C_DWIDTH-1:0] = SHADOWED ? shadow[i] : regs[i];
            end
        end
        if (mapped) begin
            rd_nxt = cur_ext;
        end else if (word == COMMIT_WORD) begin
            rd_nxt[C_NUM_REGS-1:0] = dirty;
        end
        merged    = be_merge(cur_ext, OPB_DBus, OPB_BE);
        commit_wr = SHADOWED && (word == COMMIT_WORD) && OPB_DBus[31] && OPB_BE[3];
    end

    assign err_req = ERR_UNMAPPED && !mapped && (word != COMMIT_WORD);

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                regs[i]   <= RST_VAL;
                shadow[i] <= RST_VAL;
            end
            dirty       <= '0;
            user_update <= '0;
            commit_q    <= 1'b0;
            rd_q        <= '0;
        end else begin
            user_update <= '0;
            commit_q    <= 1'b0;
            rd_q        <= (xfer_start && OPB_RNW) ? rd_nxt : 32'h0;
            if (xfer_start && !OPB_RNW) begin
                if (mapped && (|OPB_BE)) begin
                    for (int i = 0; i < C_NUM_REGS; i++) begin
                        if (word == 6'(i)) begin
                            if (SHADOWED) begin
                                shadow[i] <= merged[C_DWIDTH-1:0];
                                dirty[i]  <= 1'b1;
                            end else begin
                                regs[i]        <= merged[C_DWIDTH-1:0];
                                user_update[i] <= 1'b1;
                            end
                        end
                    end
                end else if (commit_wr) begin
                    for (int i = 0; i < C_NUM_REGS; i++) begin
                        regs[i] <= shadow[i];
                    end
                    user_update <= dirty;
                    commit_q    <= 1'b1;
                    dirty       <= '0;
                end
            end
        end
    end

    for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_out
        assign user_data_out[g*C_DWIDTH +: C_DWIDTH] = regs[g];
    end

    assign Sl_DBus     = rd_q;
    assign Sl_xferAck  = xfer_ack;
    assign Sl_errAck   = err_ack;
    assign Sl_retry    = 1'b0;
    assign Sl_toutSup  = 1'b0;
    assign user_commit = commit_q;

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Bench for the OPB register bank: a direct/err-reporting instance and a shadowed instance.
module tb_opb_register_bank_ppc2simulink;

    localparam logic [31:0] BASE = 32'h01112100;
    localparam logic [31:0] RV_S = 32'h5A5A0001;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [0:31]  abus;
    logic [0:31]  dbus;
    logic [0:3]   be;
    logic         rnw, sel_d, sel_s, seq;
    logic [0:31]  sdbus_d, sdbus_s;
    logic         ack_d, ack_s, err_d, err_s, retry_d, retry_s, tout_d, tout_s;
    logic [255:0] udo_d, udo_s;
    logic [7:0]   upd_d, upd_s;
    logic         cm_d, cm_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    opb_register_bank_ppc2simulink #(
        .C_SHADOWED (0), .C_ERR_UNMAPPED (1), .C_RESET_VAL (32'h0)
    ) dut_d (
        .OPB_Clk (clk), .OPB_Rst_n (rst_n), .OPB_ABus (abus), .OPB_BE (be),
        .OPB_DBus (dbus), .OPB_RNW (rnw), .OPB_select (sel_d), .OPB_seqAddr (seq),
        .Sl_DBus (sdbus_d), .Sl_xferAck (ack_d), .Sl_errAck (err_d), .Sl_retry (retry_d),
        .Sl_toutSup (tout_d), .user_data_out (udo_d), .user_update (upd_d), .user_commit (cm_d)
    );

    opb_register_bank_ppc2simulink #(
        .C_SHADOWED (1), .C_ERR_UNMAPPED (0), .C_RESET_VAL (RV_S)
    ) dut_s (
        .OPB_Clk (clk), .OPB_Rst_n (rst_n), .OPB_ABus (abus), .OPB_BE (be),
        .OPB_DBus (dbus), .OPB_RNW (rnw), .OPB_select (sel_s), .OPB_seqAddr (seq),
        .Sl_DBus (sdbus_s), .Sl_xferAck (ack_s), .Sl_errAck (err_s), .Sl_retry (retry_s),
        .Sl_toutSup (tout_s), .user_data_out (udo_s), .user_update (upd_s), .user_commit (cm_s)
    );

    // Reference model: index 0 = direct instance, 1 = shadowed instance.
    logic [31:0] mreg [2][8];
    logic [31:0] msh  [2][8];
    logic [7:0]  mdirty [2];

    typedef struct {
        int          d;
        logic        rnw;
        logic [7:0]  off;
        logic [31:0] dat;
        logic [3:0]  be;
        logic [31:0] x_rd;
        logic [7:0]  x_upd;
        logic        x_err;
        logic        x_cm;
    } vec_t;

    vec_t vt [20];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rv(input int d);
        return (d == 1) ? RV_S : 32'h0;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) begin
                mreg[d][i] = rv(d);
                msh[d][i]  = rv(d);
            end
            mdirty[d] = 8'h0;
        end
    endtask

    // be[j] mirrors OPB_BE[j], which enables register byte 3-j.
    function automatic logic [31:0] bmerge(input logic [31:0] old, input logic [31:0] dat, input logic [3:0] b);
        logic [31:0] r;
        r = old;
        for (int j = 0; j < 4; j++) begin
            if (b[j]) r[(3-j)*8 +: 8] = dat[(3-j)*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [255:0] exp_udo(input int d);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = mreg[d][i];
        return r;
    endfunction

    function automatic logic ack_of(input int d);
        return (d == 1) ? ack_s : ack_d;
    endfunction

    function automatic logic [31:0] rd_of(input int d);
        logic [31:0] r;
        r = (d == 1) ? sdbus_s : sdbus_d;
        return r;
    endfunction

    task automatic xfer(input int d, input logic rnw_i, input logic [7:0] off, input logic [31:0] dat,
                        input logic [3:0] be_i, output logic [31:0] rd, output logic [7:0] upd,
                        output logic err, output logic cm);
        int          w, lat;
        logic [31:0] e_rd;
        logic [7:0]  e_upd;
        logic        e_err, e_cm;
        w     = int'(off) / 4;
        e_rd  = '0;
        e_upd = '0;
        e_cm  = 1'b0;
        e_err = (d == 0) && (w >= 8) && (w != 63);
        if (rnw_i) begin
            if (w < 8)        e_rd = (d == 1) ? msh[d][w] : mreg[d][w];
            else if (w == 63) e_rd = {24'h0, mdirty[d]};
        end else if (w < 8 && be_i != 4'h0) begin
            if (d == 1) begin
                msh[1][w]    = bmerge(msh[1][w], dat, be_i);
                mdirty[1][w] = 1'b1;
            end else begin
                mreg[0][w] = bmerge(mreg[0][w], dat, be_i);
                e_upd[w]   = 1'b1;
            end
        end else if (d == 1 && w == 63 && dat[0] && be_i[3]) begin
            e_upd = mdirty[1];
            e_cm  = 1'b1;
            for (int i = 0; i < 8; i++) mreg[1][i] = msh[1][i];
            mdirty[1] = 8'h0;
        end

        abus = BASE + {24'h0, off};
        dbus = dat;
        rnw  = rnw_i;
        for (int j = 0; j < 4; j++) be[j] = be_i[j];
        sel_d = (d == 0);
        sel_s = (d == 1);
        lat = 0;
        for (int n = 1; n <= 4; n++) begin
            @(posedge clk); #1;
            if (ack_of(d)) begin
                lat = n;
                break;
            end
        end
        chk("ack_latency", lat, 1);
        rd  = rd_of(d);
        upd = (d == 1) ? upd_s : upd_d;
        err = (d == 1) ? err_s : err_d;
        cm  = (d == 1) ? cm_s : cm_d;
        chk("rdata", rd, e_rd);
        chk("errack", err, e_err);
        chk("update", upd, e_upd);
        chk("commit", cm, e_cm);
        chk("data_out", (d == 1) ? udo_s : udo_d, exp_udo(d));
        @(negedge clk);
        sel_d = 1'b0;
        sel_s = 1'b0;
        @(posedge clk); #1;
        chk("ack_single", ack_of(d), 0);
        chk("update_pulse", (d == 1) ? upd_s : upd_d, 0);
        chk("commit_pulse", (d == 1) ? cm_s : cm_d, 0);
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [7:0]  upd;
        logic        err, cm;
        int          w;
        logic [31:0] dat;
        logic [3:0]  bei;

        vt[0]  = '{0, 1'b0, 8'h08, 32'hDEADBEEF, 4'hF,    32'h0,        8'h04, 1'b0, 1'b0};
        vt[1]  = '{0, 1'b1, 8'h08, 32'h0,        4'hF,    32'hDEADBEEF, 8'h00, 1'b0, 1'b0};
        vt[2]  = '{0, 1'b0, 8'h00, 32'hAAAAAAAA, 4'hF,    32'h0,        8'h01, 1'b0, 1'b0};
        vt[3]  = '{0, 1'b0, 8'h00, 32'h11223344, 4'b0100, 32'h0,        8'h01, 1'b0, 1'b0};
        vt[4]  = '{0, 1'b1, 8'h00, 32'h0,        4'hF,    32'hAAAA33AA, 8'h00, 1'b0, 1'b0};
        vt[5]  = '{0, 1'b0, 8'h04, 32'h12345678, 4'h0,    32'h0,        8'h00, 1'b0, 1'b0};
        vt[6]  = '{0, 1'b1, 8'h04, 32'h0,        4'hF,    32'h0,        8'h00, 1'b0, 1'b0};
        vt[7]  = '{0, 1'b0, 8'h08, 32'hDEADBEEF, 4'hF,    32'h0,        8'h04, 1'b0, 1'b0};
        vt[8]  = '{0, 1'b0, 8'hFC, 32'h1,        4'b1000, 32'h0,        8'h00, 1'b0, 1'b0};
        vt[9]  = '{0, 1'b1, 8'hFC, 32'h0,        4'hF,    32'h0,        8'h00, 1'b0, 1'b0};
        vt[10] = '{0, 1'b0, 8'h40, 32'hFFFFFFFF, 4'hF,    32'h0,        8'h00, 1'b1, 1'b0};
        vt[11] = '{0, 1'b1, 8'h40, 32'h0,        4'hF,    32'h0,        8'h00, 1'b1, 1'b0};
        vt[12] = '{1, 1'b0, 8'h04, 32'h000000AB, 4'hF,    32'h0,        8'h00, 1'b0, 1'b0};
        vt[13] = '{1, 1'b0, 8'h14, 32'hCAFEF00D, 4'hF,    32'h0,        8'h00, 1'b0, 1'b0};
        vt[14] = '{1, 1'b1, 8'hFC, 32'h0,        4'hF,    32'h00000022, 8'h00, 1'b0, 1'b0};
        vt[15] = '{1, 1'b1, 8'h04, 32'h0,        4'hF,    32'h000000AB, 8'h00, 1'b0, 1'b0};
        vt[16] = '{1, 1'b0, 8'hFC, 32'h1,        4'b1000, 32'h0,        8'h22, 1'b0, 1'b1};
        vt[17] = '{1, 1'b1, 8'hFC, 32'h0,        4'hF,    32'h0,        8'h00, 1'b0, 1'b0};
        vt[18] = '{1, 1'b0, 8'h40, 32'hFFFFFFFF, 4'hF,    32'h0,        8'h00, 1'b0, 1'b0};
        vt[19] = '{1, 1'b1, 8'h14, 32'h0,        4'hF,    32'hCAFEF00D, 8'h00, 1'b0, 1'b0};

        rst_n = 1'b0; sel_d = 1'b0; sel_s = 1'b0; rnw = 1'b1; seq = 1'b0;
        abus = '0; dbus = '0; be = '0;
        model_reset();

        @(posedge clk); #1;
        chk("rst_ack_d", ack_d, 0);        chk("rst_ack_s", ack_s, 0);
        chk("rst_err_d", err_d, 0);        chk("rst_err_s", err_s, 0);
        chk("rst_dbus_d", rd_of(0), 0);    chk("rst_dbus_s", rd_of(1), 0);
        chk("rst_upd_d", upd_d, 0);        chk("rst_upd_s", upd_s, 0);
        chk("rst_cm_d", cm_d, 0);          chk("rst_cm_s", cm_s, 0);
        chk("rst_retry", {retry_d, retry_s, tout_d, tout_s}, 0);
        chk("rst_udo_d", udo_d, exp_udo(0));
        chk("rst_udo_s", udo_s, exp_udo(1));
        @(negedge clk);
        rst_n = 1'b1;

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) begin
                xfer(d, 1'b1, 8'(i * 4), 32'h0, 4'hF, rd, upd, err, cm);
            end
        end

        for (int k = 0; k < 20; k++) begin
            xfer(vt[k].d, vt[k].rnw, vt[k].off, vt[k].dat, vt[k].be, rd, upd, err, cm);
            chk($sformatf("vec%0d_rd", k), rd, vt[k].x_rd);
            chk($sformatf("vec%0d_upd", k), upd, vt[k].x_upd);
            chk($sformatf("vec%0d_err", k), err, vt[k].x_err);
            chk($sformatf("vec%0d_commit", k), cm, vt[k].x_cm);
        end

        // Select held past the ack must not be acknowledged twice.
        abus = BASE + 32'h08; rnw = 1'b1; be = 4'hF; sel_d = 1'b1;
        @(posedge clk); #1;
        chk("hold_ack", ack_d, 1);
        @(posedge clk); #1;
        chk("hold_no_reack", ack_d, 0);
        chk("hold_dbus_idle", rd_of(0), 0);
        @(negedge clk);
        sel_d = 1'b0;
        @(negedge clk);

        // Reset during the select cycle of a write, then an immediate read.
        abus = BASE + 32'h0C; dbus = 32'h0BADF00D; be = 4'hF; rnw = 1'b0; sel_d = 1'b1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rstx_no_ack", ack_d, 0);
        chk("rstx_no_upd", upd_d, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        xfer(0, 1'b1, 8'h0C, 32'h0, 4'hF, rd, upd, err, cm);
        chk("rstx_reg_held", rd, 32'h0);

        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 9))
                8:       w = 63;
                9:       w = $urandom_range(8, 62);
                default: w = $urandom_range(0, 7);
            endcase
            dat = $urandom;
            bei = 4'($urandom_range(0, 15));
            if (w == 63 && $urandom_range(0, 1) == 1) begin
                dat = 32'h1;
                bei = bei | 4'b1000;
            end
            xfer($urandom_range(0, 1), 1'($urandom_range(0, 1)), 8'(w * 4), dat, bei, rd, upd, err, cm);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/opb_register_bank_ppc2simulink.md
Name: opb_register_bank_ppc2simulink

Overview:
- Software-writable register bank on the OPB bus, driving static control values into the Simulink user logic.
- Generalises the single-register ppc2simulink block to C_NUM_REGS registers of C_DWIDTH bits, with byte-enable writes, readback and per-register update strobes.
- Optional shadowed mode: all outputs change atomically on a software commit.
- User logic runs on the OPB clock; no clock-domain crossing.

Parameters:
- C_BASEADDR, 32'h01112100: window base; 256-byte window, 64 words.
- C_HIGHADDR, 32'h011121FF: window top; C_HIGHADDR-C_BASEADDR+1 must equal 256.
- C_NUM_REGS, 8: register count, 1..63.
- C_DWIDTH, 32: bits per register, 1..32.
- C_RESET_VAL, 32'h0: reset value of every register and shadow; low C_DWIDTH bits used.
- C_SHADOWED, 0: 0 = direct writes; 1 = shadow plus commit.
- C_ERR_UNMAPPED, 0: 1 = assert Sl_errAck on access to unmapped offsets.

Ports:
- OPB_Clk  in  1  single clock for bus and user side.
- OPB_Rst_n  in  1  reset, asynchronous, active-low.
- OPB_ABus  in  [0:31]  address.
- OPB_BE  in  [0:3]  byte enables; BE[0] covers DBus[0:7].
- OPB_DBus  in  [0:31]  write data.
- OPB_RNW  in  1  1 = read.
- OPB_select  in  1  transfer request.
- OPB_seqAddr  in  1  ignored.
- Sl_DBus  out  [0:31]  read data; zero unless Sl_xferAck is high.
- Sl_xferAck  out  1  transfer acknowledge.
- Sl_errAck  out  1  error acknowledge.
- Sl_retry  out  1  tied 0.
- Sl_toutSup  out  1  tied 0.
- user_data_out  out  C_NUM_REGS*C_DWIDTH  register i occupies bits [i*C_DWIDTH +: C_DWIDTH].
- user_update  out  C_NUM_REGS  one-cycle pulse per register whose output changed by a write or commit.
- user_commit  out  1  one-cycle pulse on commit; C_SHADOWED=1 only, else tied 0.

Behaviour:
- Reset (async assert, sync release): all registers and shadows = C_RESET_VAL; dirty mask = 0; Sl_xferAck = Sl_errAck = 0; Sl_DBus = 0; user_update = 0; user_commit = 0.
- Bit order: OPB bit DBus[31-k] maps to register bit k. Register bits at or above C_DWIDTH are discarded on write and read back as 0.
- Decode: hit = OPB_select and (OPB_ABus & ~32'hFF) == C_BASEADDR. Word offset w = OPB_ABus[24:29].
- Handshake:
  - A hit with no ack pending raises Sl_xferAck on the next edge for exactly one cycle.
  - The master holds select until ack. The cycle after an ack never re-acks the same transfer; ack is gated by a registered ack_q.
  - Latency: select high at edge t gives xferAck high during cycle t+1.
- Write to w < C_NUM_REGS, per enabled byte:
  - C_SHADOWED=0: register updated at the edge raising xferAck; user_update[w] high in the same cycle as xferAck.
  - C_SHADOWED=1: shadow[w] updated and dirty[w] set; outputs unchanged.
- Write to w = 63 with DBus[31]=1 and BE[3]=1, C_SHADOWED=1:
  - every output copies its shadow at the edge raising xferAck;
  - user_update = dirty mask and user_commit = 1, both for one cycle;
  - dirty mask cleared.
  - When C_SHADOWED=0 this write is ignored.
- Read: Sl_DBus during the ack cycle returns:
  - w < C_NUM_REGS: shadow[w] if shadowed, else register[w];
  - w = 63: dirty mask, zero-extended;
  - any other offset: 0.
- Unmapped offsets (C_NUM_REGS <= w < 63):
  - writes are ignored, reads return 0;
  - xferAck is issued normally;
  - Sl_errAck is asserted in the ack cycle iff C_ERR_UNMAPPED=1.
- BE all zero: transfer acked, no state change, no update pulse.
- Reset mid-transfer: ack aborted immediately, no partial write, no strobes; the master retimes out.
- A write of an identical value still pulses user_update; the strobe means written, not changed.

Decomposition:
- Package opb_regbank_pkg holds:
  - COMMIT_WORD = 6'd63;
  - WINDOW_MASK = 32'hFFFFFF00;
  - a function applying byte enables to a C_DWIDTH value with OPB bit reversal.
- Sub-module opb_slave_ack: address decode, ack_q and the xferAck/errAck generation, reused by later OPB slaves.
- Register storage, commit logic and the read mux stay in the top.

Test Plan:
- Reset, then read all 8 offsets -> each returns C_RESET_VAL; user_update stays 0.
- C_SHADOWED=0: write 32'hDEADBEEF to offset 0x08 -> user_data_out reg2 = 32'hDEADBEEF and user_update = 8'b00000100, both in the xferAck cycle, one cycle after select.
- Byte-enable write of 32'h11223344 with BE=4'b0100 over reg0 = 32'hAAAAAAAA -> reg0 reads 32'hAAAA33AA.
- C_SHADOWED=1: write regs 1 and 5, read 0xFC -> 32'h22; outputs still C_RESET_VAL. Write 1 to 0xFC -> both outputs update together, user_update = 8'h22, user_commit pulses once, 0xFC then reads 0.
- C_ERR_UNMAPPED=1: write offset 0x40 -> xferAck and errAck high together; subsequent read of 0x40 returns 0; no strobe.
- Assert OPB_Rst_n low during the select cycle of a write -> no ack, register holds C_RESET_VAL after release; a back-to-back read then acks normally.
